// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and width constants for the memory-port arbiter slice.
// State and owner encodings are fixed so they stay readable in waveforms.
package mem_port_arbiter_pkg;

  localparam int unsigned REG_BUS    = 64;
  localparam int unsigned ADDR_W_DEF = REG_BUS;
  localparam int unsigned DATA_W_DEF = REG_BUS;
  localparam int unsigned STRB_W     = 8;
  localparam int unsigned INSN_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner select between fetch and load/store, with a streak counter that
// forces a fetch grant after MAX_LS_STREAK back-to-back LS wins.
module mem_arb_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   arb,
  output owner_t winner,
  output logic   grant
);

  localparam int unsigned SW = $clog2(MAX_LS_STREAK + 1);

  logic [SW-1:0] streak;

  always_comb begin
    grant  = arb && (if_req || ls_req);
    winner = OWN_LS;
    if (if_req && (!ls_req || streak == SW'(MAX_LS_STREAK)))
      winner = OWN_IF;
  end

  // Only LS wins that actually deprive a waiting fetch extend the streak.
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
    end else if (grant) begin
      if (winner == OWN_LS && if_req)
        streak <= streak + 1'b1;
      else
        streak <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and
// load/store, with a timeout that turns a hung access into an error response.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [INSN_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [STRB_W-1:0] ls_wstrb,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t            state, state_n;
  owner_t            owner, winner;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [TW-1:0]     tcnt;
  logic              timeout_hit;

  mem_arb_sel #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_sel (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .ls_req (ls_req),
    .arb    (state == IDLE),
    .winner (winner),
    .grant  (grant)
  );

  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (grant) state_n = REQ;
      REQ: begin
        if (timeout_hit)  state_n = RESP;
        else if (mem_gnt) state_n = WAIT;
      end
      WAIT: if (mem_rvalid || timeout_hit) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= winner;
            tcnt  <= '0;
            if (winner == OWN_LS) begin
              addr_q  <= ls_addr;
              we_q    <= ls_we;
              wdata_q <= ls_wdata;
              wstrb_q <= ls_wstrb;
            end else begin
              addr_q  <= if_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
              wstrb_q <= '0;
            end
          end
        end
        REQ, WAIT: begin
          tcnt <= tcnt + 1'b1;
          // A real response in WAIT beats a coincident timeout.
          if (state == WAIT && mem_rvalid) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_ready  = (state == IDLE);
  assign ls_ready  = (state == IDLE);
  assign if_rvalid = (state == RESP) && (owner == OWN_IF);
  assign ls_rvalid = (state == RESP) && (owner == OWN_LS);
  assign if_rdata  = addr_q[2] ? rdata_q[2*INSN_W-1:INSN_W] : rdata_q[INSN_W-1:0];
  assign if_err    = err_q;
  assign ls_rdata  = rdata_q;
  assign ls_err    = err_q;
  assign mem_req   = (state == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule
